// File: rtl/bumper_hit_controller.sv
// Bumper hit sequencer: edge-detects per-bumper collisions, grants them round-robin
// and runs a frame-timed flash then cooldown per grant, with score pulse and hit count.
module bumper_hit_controller #(
  parameter int FLASH_FRAMES    = 8,
  parameter int BLINK_FRAMES    = 2,
  parameter int COOLDOWN_FRAMES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       enable,
  input  logic [3:0] collision,
  output logic [3:0] hitFlash,
  output logic [1:0] activeBumper,
  output logic       busy,
  output logic       scorePulse,
  output logic [7:0] hitCount
);
  // state   | meaning
  // S_IDLE  | waiting for enable and a pending request
  // S_FLASH | granted bumper blinks for FLASH_FRAMES frames
  // S_COOL  | quiet period of COOLDOWN_FRAMES frames before the next grant
  typedef enum logic [1:0] {S_IDLE, S_FLASH, S_COOL} state_t;

  localparam logic [7:0] FLASH_TC = 8'(FLASH_FRAMES);
  localparam logic [7:0] COOL_TC  = 8'(COOLDOWN_FRAMES);
  localparam logic [3:0] BLINK_TC = 4'(BLINK_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] coll_hist_q;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] active_q, active_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] blink_q, blink_d;
  logic       phase_q, phase_d;
  logic [7:0] hit_count_q, hit_count_d;
  logic [3:0] hit_flash_q, hit_flash_d;
  logic       busy_q, busy_d;
  logic       score_q, score_d;

  logic [3:0] rise, ignore_mask, grant_mask;
  logic [1:0] idx, grant_idx;
  logic       grant_found, grant;

  // Round-robin search upward from the pointer, wrapping 3 -> 0.
  always_comb begin
    idx         = 2'd0;
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!grant_found && pending_q[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    active_d    = active_q;
    timer_d     = timer_q;
    blink_d     = blink_q;
    phase_d     = phase_q;
    hit_count_d = hit_count_q;
    grant       = 1'b0;

    rise        = collision & ~coll_hist_q;
    ignore_mask = (state_q == S_FLASH) ? (4'b0001 << active_q) : 4'b0000;

    case (state_q)
      S_IDLE: begin
        if (enable && grant_found) begin
          grant    = 1'b1;
          state_d  = S_FLASH;
          active_d = grant_idx;
          ptr_d    = grant_idx + 2'd1;
          timer_d  = FLASH_TC;
          blink_d  = BLINK_TC;
          phase_d  = 1'b1;
          if (hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
        end
      end
      S_FLASH: begin
        if (startOfFrame) begin
          if (timer_q == 8'd1) begin
            if (COOLDOWN_FRAMES == 0) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_COOL;
              timer_d = COOL_TC;
            end
          end else begin
            timer_d = timer_q - 8'd1;
          end
          if (blink_q == 4'd1) begin
            blink_d = BLINK_TC;
            phase_d = ~phase_q;
          end else begin
            blink_d = blink_q - 4'd1;
          end
        end
      end
      S_COOL: begin
        if (startOfFrame) begin
          if (timer_q == 8'd1) state_d = S_IDLE;
          else                 timer_d = timer_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    grant_mask = grant ? (4'b0001 << grant_idx) : 4'b0000;
    pending_d  = (pending_q & ~grant_mask) | (rise & ~ignore_mask);

    // Disable flushes the queue but keeps pointer, count and last active bumper.
    if (!enable) begin
      state_d   = S_IDLE;
      pending_d = 4'b0000;
    end

    score_d     = grant;
    busy_d      = (state_d != S_IDLE);
    hit_flash_d = (state_d == S_FLASH && phase_d) ? (4'b0001 << active_d) : 4'b0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pending_q   <= 4'b0000;
      coll_hist_q <= 4'b0000;
      ptr_q       <= 2'd0;
      active_q    <= 2'd0;
      timer_q     <= 8'd0;
      blink_q     <= 4'd0;
      phase_q     <= 1'b0;
      hit_count_q <= 8'd0;
      hit_flash_q <= 4'b0000;
      busy_q      <= 1'b0;
      score_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      coll_hist_q <= collision;
      ptr_q       <= ptr_d;
      active_q    <= active_d;
      timer_q     <= timer_d;
      blink_q     <= blink_d;
      phase_q     <= phase_d;
      hit_count_q <= hit_count_d;
      hit_flash_q <= hit_flash_d;
      busy_q      <= busy_d;
      score_q     <= score_d;
    end
  end

  assign hitFlash     = hit_flash_q;
  assign activeBumper = active_q;
  assign busy         = busy_q;
  assign scorePulse   = score_q;
  assign hitCount     = hit_count_q;
endmodule

// File: tb/tb_bumper_hit_controller.sv
// Scoreboard bench: a frame-level reference model predicts grants and flash/busy,
// a monitor compares them; a second instance covers zero cooldown and saturation.
module tb_bumper_hit_controller;
  localparam int FLASH = 8;
  localparam int BLINK = 2;
  localparam int COOL  = 16;
  localparam int P0    = 4;

  logic       clk = 1'b0;
  logic       reset, sof, enable;
  logic [3:0] collision;
  logic [3:0] hitFlash;
  logic [1:0] activeBumper;
  logic       busy, scorePulse;
  logic [7:0] hitCount;

  logic       rst0;
  logic       sof0  = 1'b0;
  logic [3:0] coll0 = 4'b0000;
  logic [3:0] hitFlash0;
  logic [1:0] activeBumper0;
  logic       busy0, scorePulse0;
  logic [7:0] hitCount0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bumper_hit_controller #(.FLASH_FRAMES(FLASH), .BLINK_FRAMES(BLINK), .COOLDOWN_FRAMES(COOL)) u_dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .enable(enable), .collision(collision),
    .hitFlash(hitFlash), .activeBumper(activeBumper), .busy(busy),
    .scorePulse(scorePulse), .hitCount(hitCount));

  bumper_hit_controller #(.FLASH_FRAMES(FLASH), .BLINK_FRAMES(BLINK), .COOLDOWN_FRAMES(0)) u_dut0 (
    .clk(clk), .reset(rst0), .startOfFrame(sof0), .enable(1'b1), .collision(coll0),
    .hitFlash(hitFlash0), .activeBumper(activeBumper0), .busy(busy0),
    .scorePulse(scorePulse0), .hitCount(hitCount0));

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: service mode 0 idle / 1 flash / 2 cooldown, frames counted since grant.
  typedef struct {int who; int hits;} grant_t;
  grant_t sb_q[$];
  int     m_mode, m_sof, m_who, m_ptr, m_hits, m_old_mode, m_old_who;
  bit     m_found;
  bit [3:0] m_pend, m_prev, m_rise;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_sof = 0; m_who = 0; m_ptr = 0; m_hits = 0;
      m_pend = '0; m_prev = '0;
      sb_q.delete();
    end else begin
      m_rise     = collision & ~m_prev;
      m_prev     = collision;
      m_old_mode = m_mode;
      m_old_who  = m_who;
      if (!enable) begin
        m_mode = 0;
        m_pend = '0;
      end else begin
        if (m_mode == 0) begin
          if (m_pend != 0) begin
            m_found = 0;
            for (int k = 0; k < 4; k++)
              if (!m_found && m_pend[2'((m_ptr + k) % 4)]) begin
                m_found = 1;
                m_who   = (m_ptr + k) % 4;
              end
            m_pend[2'(m_who)] = 1'b0;
            m_ptr = (m_who + 1) % 4;
            if (m_hits < 255) m_hits++;
            sb_q.push_back('{m_who, m_hits});
            m_mode = 1;
            m_sof  = 0;
          end
        end else if (sof) begin
          m_sof++;
          if (m_mode == 1 && m_sof == FLASH)             m_mode = (COOL == 0) ? 0 : 2;
          else if (m_mode == 2 && m_sof == FLASH + COOL) m_mode = 0;
        end
        for (int i = 0; i < 4; i++)
          if (m_rise[i] && !(m_old_mode == 1 && i == m_old_who)) m_pend[i] = 1'b1;
      end
    end
  end

  logic [3:0] ef;
  grant_t     g;
  always @(negedge clk) begin
    if (!reset) begin
      if (scorePulse) begin
        if (sb_q.size() == 0) check("spurious_grant", 1, 0);
        else begin
          g = sb_q.pop_front();
          check("grant_bumper", activeBumper, g.who);
          check("grant_count", hitCount, g.hits);
        end
      end
      check("sb_backlog", sb_q.size(), 0);
      check("busy", busy, (m_mode != 0) ? 1 : 0);
      ef = (m_mode == 1 && ((m_sof / BLINK) % 2 == 0)) ? (4'b0001 << m_who) : 4'b0000;
      check("hit_flash", hitFlash, ef);
    end
  end

  // Zero-cooldown instance: alternating bumpers re-rise every frame, fixed frame period.
  int c0_cyc = 0, n0 = 0, last_cyc0 = 0, last_who0 = 0;
  always @(negedge clk) begin
    if (rst0) begin
      c0_cyc = 0;
      sof0   = 1'b0;
      coll0  = 4'b0000;
    end else begin
      c0_cyc++;
      sof0 = (c0_cyc % P0 == 0);
      if (c0_cyc % P0 == 0) coll0 = (coll0 == 4'b0001) ? 4'b0010 : 4'b0001;
      if (scorePulse0) begin
        n0++;
        check("sat_count", hitCount0, (n0 < 255) ? n0 : 255);
        if (n0 >= 2) begin
          check("alt_bumper", activeBumper0, 1 - last_who0);
          check("zero_cool_gap", c0_cyc - last_cyc0, FLASH * P0);
        end
        last_cyc0 = c0_cyc;
        last_who0 = activeBumper0;
      end
    end
  end

  task automatic drive(input logic [3:0] c, input logic e, input logic s);
    collision = c;
    enable    = e;
    sof       = s;
    @(negedge clk);
  endtask

  task automatic frames(input int n, input logic [3:0] c);
    for (int f = 0; f < n; f++) begin
      drive(c, 1'b1, 1'b1);
      drive(c, 1'b1, 1'b0);
      drive(c, 1'b1, 1'b0);
    end
  endtask

  logic [3:0] rc;
  int         rb;
  initial begin
    reset = 1'b1; rst0 = 1'b1; collision = 4'b0000; enable = 1'b0; sof = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_flash", hitFlash, 0);
    check("rst_busy", busy, 0);
    check("rst_pulse", scorePulse, 0);
    check("rst_active", activeBumper, 0);
    check("rst_count", hitCount, 0);
    reset = 1'b0; rst0 = 1'b0;

    // single hit on bumper 2, level held
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0100, 1'b1, 1'b0);
    drive(4'b0100, 1'b1, 1'b0);
    check("lat_pulse", scorePulse, 1);
    check("lat_bumper", activeBumper, 2);
    check("lat_count", hitCount, 1);
    drive(4'b0100, 1'b1, 1'b0);
    check("pulse_width", scorePulse, 0);
    frames(30, 4'b0100);
    check("held_no_regrant", hitCount, 1);
    check("single_idle", busy, 0);

    // round robin from a fresh pointer
    reset = 1'b1;
    drive(4'b0000, 1'b1, 1'b0);
    reset = 1'b0;
    drive(4'b0000, 1'b1, 1'b0);
    frames(80, 4'b1011);
    check("rr_count", hitCount, 3);
    frames(2, 4'b0000);
    frames(60, 4'b1001);
    check("rr2_count", hitCount, 5);

    // reset in the middle of a flash
    drive(4'b0010, 1'b1, 1'b0);
    drive(4'b0010, 1'b1, 1'b0);
    drive(4'b0010, 1'b1, 1'b0);
    frames(2, 4'b0010);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_flash", hitFlash, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_active", activeBumper, 0);
    check("mid_rst_count", hitCount, 0);
    @(negedge clk);
    reset = 1'b0;
    frames(30, 4'b0010);
    check("post_reset_count", hitCount, 1);

    // re-hit on bumper 1: ignored in flash, queued in cooldown
    frames(1, 4'b0000);
    drive(4'b0010, 1'b1, 1'b0);
    frames(2, 4'b0010);
    frames(1, 4'b0000);
    frames(1, 4'b0010);
    frames(6, 4'b0010);
    frames(1, 4'b0000);
    frames(1, 4'b0010);
    frames(40, 4'b0010);
    check("rehit_count", hitCount, 3);

    // enable flush with bumpers 0 and 2 queued
    frames(1, 4'b0000);
    drive(4'b0101, 1'b1, 1'b0);
    frames(2, 4'b0101);
    drive(4'b0101, 1'b0, 1'b0);
    check("flush_busy", busy, 0);
    check("flush_flash", hitFlash, 0);
    frames(40, 4'b0101);
    check("flush_count", hitCount, 4);
    check("flush_idle", busy, 0);

    // randomized traffic
    rc = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        rb = $urandom_range(0, 3);
        rc[rb] = ~rc[rb];
      end
      drive(rc, ($urandom_range(0, 149) != 0), ($urandom_range(0, 2) == 0));
    end
    drive(rc, 1'b1, 1'b0);
    drive(rc, 1'b1, 1'b0);

    for (int i = 0; i < 15000 && n0 < 260; i++) @(negedge clk);
    check("sat_done", (n0 >= 260) ? 1 : 0, 1);
    check("sat_final", hitCount0, 255);
    check("sb_drain", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
